scan_cfg_loader: RTL

- Bitstream driver for the fabric's two configuration scan chains (CLB chain and connection chain).
- Accepts packed config words from the host over a valid/ready stream, serializes them into the array's clb_scan_in and conn_scan_in, generates scan_clk and both scan enables, and packs the bits shifted out of the chain tails into readback words.
- Sits between the host/config port and the top-level CLB array.

---
 rtl/scan_cfg_loader.sv | 92 +++++++++
 1 files changed

// File: rtl/scan_cfg_loader.sv
// scan_cfg_loader: serializes host config words into the CLB and connection scan chains and packs chain readback.
module scan_cfg_loader #(
  parameter int CLB_CHAIN_LEN = 2048,
  parameter int CONN_CHAIN_LEN = 3072,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              scan_clk,
  output logic              clb_scan_en,
  output logic              clb_scan_in,
  input  logic              clb_scan_out,
  output logic              conn_scan_en,
  output logic              conn_scan_in,
  input  logic              conn_scan_out,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);
  localparam int TOTAL = CLB_CHAIN_LEN + CONN_CHAIN_LEN;
  localparam int BW = $clog2(TOTAL + 1);
  localparam int IW = WORD_W > 1 ? $clog2(WORD_W) : 1;
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, SHIFT_LO = 3'd2, SHIFT_HI = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic [BW-1:0] bit_cnt;
  logic [IW-1:0] idx;
  logic [WORD_W-1:0] word, rb_buf;
  logic shifting, in_clb, last, word_end, bit_val;
  always_comb begin
    shifting = state == SHIFT_LO || state == SHIFT_HI;
    in_clb = bit_cnt < BW'(CLB_CHAIN_LEN);
    last = bit_cnt == BW'(TOTAL - 1);
    word_end = idx == IW'(WORD_W - 1);
    bit_val = word[idx];
    cfg_ready = state == FETCH;
    busy = state == FETCH || shifting;
    done = state == DONE;
    clb_scan_en = shifting && in_clb;
    conn_scan_en = shifting && !in_clb;
    clb_scan_in = clb_scan_en && bit_val;
    conn_scan_in = conn_scan_en && bit_val;
  end
  // scan_clk is a flop mirroring SHIFT_HI so the chains see a glitch-free clock
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      scan_clk <= 1'b0;
      rb_valid <= 1'b0;
      rb_data <= '0;
      rb_buf <= '0;
      word <= '0;
      bit_cnt <= '0;
      idx <= '0;
    end else begin
      scan_clk <= state == SHIFT_LO;
      rb_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          bit_cnt <= '0;
          idx <= '0;
          rb_buf <= '0;
        end
        FETCH: if (cfg_valid) begin
          word <= cfg_data;
          state <= SHIFT_LO;
        end
        SHIFT_LO: begin
          rb_buf[idx] <= in_clb ? clb_scan_out : conn_scan_out;
          state <= SHIFT_HI;
        end
        SHIFT_HI: begin
          bit_cnt <= bit_cnt + 1'b1;
          idx <= word_end ? '0 : idx + 1'b1;
          if (word_end || last) begin
            rb_valid <= 1'b1;
            rb_data <= rb_buf;
            rb_buf <= '0;
          end
          state <= last ? DONE : word_end ? FETCH : SHIFT_LO;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
